// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, mem_op encodings and op decode helpers for the MEM stage.
package mem_access_pkg;
  localparam int Reglen = 32;
  localparam int RegAddrlen = 5;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;
  function automatic logic is_load(input logic [3:0] op);
    return op >= MEM_LB && op <= MEM_LHU;
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op >= MEM_SB && op <= MEM_SW;
  endfunction
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    return (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 3'd1 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext: sign/zero extends the assembled load bytes according to mem_op.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [Reglen-1:0] data,
  input  logic [3:0]        op,
  output logic [Reglen-1:0] ext
);
  always_comb
    ext = op == MEM_LB  ? {{24{data[7]}}, data[7:0]} :
          op == MEM_LH  ? {{16{data[15]}}, data[15:0]} :
          op == MEM_LBU ? {24'b0, data[7:0]} :
          op == MEM_LHU ? {16'b0, data[15:0]} : data;
endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage running loads/stores as byte-serial transfers on an 8-bit port.
// Optional MISALIGN_CHECK_EN traps misaligned halfword/word accesses and adds mem_misalign.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [Reglen-1:0]     ex_rd_data,
  input  logic [RegAddrlen-1:0] ex_rd_addr,
  input  logic                  ex_rd_enable,
  input  logic [3:0]            ex_mem_op,
  input  logic [Reglen-1:0]     ex_mem_addr,
  input  logic [Reglen-1:0]     ex_mem_wdata,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [Reglen-1:0]     mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic [7:0]            mc_rdata,
  input  logic                  mc_ack,
  output logic [Reglen-1:0]     mem_rd_data,
  output logic [RegAddrlen-1:0] mem_rd_addr,
  output logic                  mem_rd_enable,
  output logic                  mem_stall_req
`ifdef MISALIGN_CHECK_EN
  , output logic                mem_misalign
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [Reglen-1:0] buf_q, buf_d;
  logic [Reglen-1:0] ext;
  logic ld, st, mis, idle, access, done;
  assign ld = is_load(ex_mem_op);
  assign st = is_store(ex_mem_op);
  assign idle = state_q == IDLE;
  assign access = state_q == ACCESS;
  assign done = state_q == DONE;
`ifdef MISALIGN_CHECK_EN
  assign mis = ((ex_mem_op == MEM_LH || ex_mem_op == MEM_LHU || ex_mem_op == MEM_SH) && ex_mem_addr[0]) ||
               ((ex_mem_op == MEM_LW || ex_mem_op == MEM_SW) && |ex_mem_addr[1:0]);
  assign mem_misalign = !rst && done && mis;
`else
  assign mis = 1'b0;
`endif
  load_ext u_load_ext (.data(buf_q), .op(ex_mem_op), .ext(ext));
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    n_d = n_q;
    buf_d = buf_q;
    case (state_q)
      IDLE: if (ld || st) begin
        state_d = mis ? DONE : ACCESS;
        k_d = 2'd0;
        n_d = op_bytes(ex_mem_op);
        buf_d = '0;
      end
      ACCESS: if (mc_ack) begin
        if (ld) buf_d[{k_q, 3'b000} +: 8] = mc_rdata;
        k_d = k_q + 2'd1;
        if ({1'b0, k_q} == n_q - 3'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      k_q <= 2'd0;
      n_q <= 3'd1;
      buf_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      buf_q <= buf_d;
    end
  // Every output is forced to its reset value while rst is high, even combinational paths.
  always_comb begin
    mem_stall_req = !rst && ((idle && (ld || st)) || access);
    mc_req = !rst && access;
    mc_we = !rst && access && st;
    mc_addr = (!rst && access) ? ex_mem_addr + {30'b0, k_q} : '0;
    mc_wdata = (!rst && access && st) ? ex_mem_wdata[{k_q, 3'b000} +: 8] : 8'h00;
    mem_rd_data = rst ? '0 : (done && ld) ? ext : ex_rd_data;
    mem_rd_addr = rst ? '0 : ex_rd_addr;
    mem_rd_enable = !rst && ex_rd_enable && !mem_stall_req && !(done && mis);
  end
endmodule
